// File: rtl/led_shift_responder.sv
// LED pattern responder: each change of addr is a step; every STEP_DIV steps the one-hot pattern shifts.
// Latency 1 cycle from addr change to data_out; en is a synchronous active-high reset; LED_SHIFT_BOUNCE_EN selects bounce over rotate.
module led_shift_responder #(
    parameter int STEP_DIV = 1
) (
    input  logic        clk,
    input  logic        en,
    input  logic [11:0] addr,
    output logic [3:0]  data_out
);

`ifdef LED_SHIFT_BOUNCE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LEFT = 2'd1} state_t;
`endif

    localparam logic [3:0] DIV_LAST = 4'(STEP_DIV - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_data;
    logic [3:0]  w_data_nxt;
    logic [3:0]  r_div_cnt;
    logic [3:0]  w_div_nxt;
    logic [11:0] r_addr_q;
    logic        w_step;
    logic        w_div_hit;

    // addr_q tracks addr even in reset, so releasing en never fakes a step
    assign w_step    = (addr != r_addr_q) && !en;
    assign w_div_hit = (r_div_cnt == DIV_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_div_nxt   = r_div_cnt;
        case (r_state)
            IDLE: begin
                if (w_step) begin
                    w_state_nxt = LEFT;
                    w_data_nxt  = 4'b0001;
                    w_div_nxt   = 4'd0;
                end
            end
            LEFT: begin
                if (w_step) begin
                    if (w_div_hit) begin
                        w_div_nxt = 4'd0;
`ifdef LED_SHIFT_BOUNCE_EN
                        w_data_nxt = r_data << 1;
                        if (r_data == 4'b0100) begin
                            w_state_nxt = RIGHT;
                        end
`else
                        w_data_nxt = (r_data == 4'b1000) ? 4'b0001 : (r_data << 1);
`endif
                    end else begin
                        w_div_nxt = r_div_cnt + 4'd1;
                    end
                end
            end
`ifdef LED_SHIFT_BOUNCE_EN
            RIGHT: begin
                if (w_step) begin
                    if (w_div_hit) begin
                        w_div_nxt  = 4'd0;
                        w_data_nxt = r_data >> 1;
                        if (r_data == 4'b0010) begin
                            w_state_nxt = LEFT;
                        end
                    end else begin
                        w_div_nxt = r_div_cnt + 4'd1;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
                w_data_nxt  = 4'b0000;
                w_div_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        r_addr_q <= addr;
        if (en) begin
            r_state   <= IDLE;
            r_data    <= 4'b0000;
            r_div_cnt <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_data    <= w_data_nxt;
            r_div_cnt <= w_div_nxt;
        end
    end

    assign data_out = r_data;

endmodule

// File: tb/tb_led_shift_responder.sv
module tb_led_shift_responder;

    logic        clk = 1'b0;
    logic        en1;
    logic [11:0] addr1;
    logic [3:0]  data1;
    logic        en3;
    logic [11:0] addr3;
    logic [3:0]  data3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_shift_responder #(.STEP_DIV(1)) dut1 (
        .clk      (clk),
        .en       (en1),
        .addr     (addr1),
        .data_out (data1)
    );

    led_shift_responder #(.STEP_DIV(3)) dut3 (
        .clk      (clk),
        .en       (en3),
        .addr     (addr3),
        .data_out (data3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] vals [5];
        vals[0] = 12'h5A5; vals[1] = 12'h0F0; vals[2] = 12'hABC;
        vals[3] = 12'h777; vals[4] = 12'h123;
        en1 = 1'b1;
        en3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            addr1 = vals[i];
            addr3 = vals[i];
            tick();
        end
        checks++;
        if (data1 !== 4'b0000) begin
            failures++;
            $display("FAIL reset_held dut1 got=%b exp=0000", data1);
        end
        checks++;
        if (data3 !== 4'b0000) begin
            failures++;
            $display("FAIL reset_held dut3 got=%b exp=0000", data3);
        end
        en1 = 1'b0;
        en3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (data1 !== 4'b0000) begin
                failures++;
                $display("FAIL reset_release_nostep cyc=%0d got=%b exp=0000", i, data1);
            end
        end
        // first real step after release must start at 0001 (IDLE behaviour)
        addr1 = 12'h124;
        tick();
        checks++;
        if (data1 !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_step got=%b exp=0001", data1);
        end
    endtask

    task automatic test_walk();
        logic [3:0] exp_walk [8];
        logic [3:0] prev;
`ifdef LED_SHIFT_BOUNCE_EN
        exp_walk[0] = 4'b0001; exp_walk[1] = 4'b0010; exp_walk[2] = 4'b0100; exp_walk[3] = 4'b1000;
        exp_walk[4] = 4'b0100; exp_walk[5] = 4'b0010; exp_walk[6] = 4'b0001; exp_walk[7] = 4'b0010;
`else
        exp_walk[0] = 4'b0001; exp_walk[1] = 4'b0010; exp_walk[2] = 4'b0100; exp_walk[3] = 4'b1000;
        exp_walk[4] = 4'b0001; exp_walk[5] = 4'b0010; exp_walk[6] = 4'b0100; exp_walk[7] = 4'b1000;
`endif
        en1   = 1'b1;
        addr1 = 12'h000;
        tick();
        en1 = 1'b0;
        tick();
        prev = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            tick();
            tick();
            tick();
            addr1 = 12'(k + 1);
            checks++;
            if (data1 !== prev) begin
                failures++;
                $display("FAIL walk_hold step=%0d got=%b exp=%b", k, data1, prev);
            end
            tick();
            checks++;
            if (data1 !== exp_walk[k]) begin
                failures++;
                $display("FAIL walk_step step=%0d got=%b exp=%b", k, data1, exp_walk[k]);
            end
            prev = exp_walk[k];
        end
    endtask

    task automatic test_div3_back_to_back();
        logic [3:0] exp3 [7];
        exp3[0] = 4'b0001; exp3[1] = 4'b0001; exp3[2] = 4'b0001; exp3[3] = 4'b0010;
        exp3[4] = 4'b0010; exp3[5] = 4'b0010; exp3[6] = 4'b0100;
        en3   = 1'b1;
        addr3 = 12'h000;
        tick();
        en3 = 1'b0;
        tick();
        for (int k = 0; k < 7; k++) begin
            addr3 = 12'(k + 1);
            tick();
            checks++;
            if (data3 !== exp3[k]) begin
                failures++;
                $display("FAIL div3_step step=%0d got=%b exp=%b", k + 1, data3, exp3[k]);
            end
        end
    endtask

    task automatic test_en_abort();
        // continues from div3 test: data=0100, div_cnt=0
        addr3 = 12'h008;
        tick();
        checks++;
        if (data3 !== 4'b0100) begin
            failures++;
            $display("FAIL abort_pre got=%b exp=0100", data3);
        end
        en3 = 1'b1;
        tick();
        en3 = 1'b0;
        checks++;
        if (data3 !== 4'b0000) begin
            failures++;
            $display("FAIL abort_cleared got=%b exp=0000", data3);
        end
        tick();
        checks++;
        if (data3 !== 4'b0000) begin
            failures++;
            $display("FAIL abort_no_residual got=%b exp=0000", data3);
        end
        addr3 = 12'h009;
        tick();
        checks++;
        if (data3 !== 4'b0001) begin
            failures++;
            $display("FAIL abort_restart got=%b exp=0001", data3);
        end
        // div_cnt must have been cleared: two more steps hold, third shifts
        addr3 = 12'h00A;
        tick();
        addr3 = 12'h00B;
        tick();
        checks++;
        if (data3 !== 4'b0001) begin
            failures++;
            $display("FAIL abort_div_hold got=%b exp=0001", data3);
        end
        addr3 = 12'h00C;
        tick();
        checks++;
        if (data3 !== 4'b0010) begin
            failures++;
            $display("FAIL abort_div_shift got=%b exp=0010", data3);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] seq [5];
        logic [3:0]  expw [5];
        seq[0] = 12'hFFD; seq[1] = 12'hFFE; seq[2] = 12'hFFF; seq[3] = 12'h000; seq[4] = 12'h001;
        expw[0] = 4'b0001; expw[1] = 4'b0010; expw[2] = 4'b0100; expw[3] = 4'b1000;
`ifdef LED_SHIFT_BOUNCE_EN
        expw[4] = 4'b0100;
`else
        expw[4] = 4'b0001;
`endif
        en1   = 1'b1;
        addr1 = 12'hFFC;
        tick();
        en1 = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            addr1 = seq[k];
            tick();
            checks++;
            if (data1 !== expw[k]) begin
                failures++;
                $display("FAIL wrap addr=%h got=%b exp=%b", seq[k], data1, expw[k]);
            end
        end
    endtask

    initial begin
        en1   = 1'b1;
        en3   = 1'b1;
        addr1 = 12'h000;
        addr3 = 12'h000;
        tick();
        test_reset();
        test_walk();
        test_div3_back_to_back();
        test_en_abort();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_shift_responder.md
LED_SHIFT_RESPONDER -- requirements
Module: led_shift_responder

Interface
REQ-001 SHALL have parameter STEP_DIV, default 1, number of address-step events per pattern shift; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port en  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port addr  input  12  step address from the counter-driving initiator; only changes of value are significant.
REQ-005 SHALL have port data_out  output  4  registered LED pattern returned to the initiator.

Function
REQ-006 SHALL register addr into addr_q every clk cycle, including while en=1.
REQ-007 SHALL define a step event as (addr != addr_q) while en=0; consecutive-cycle changes each count as one step.
REQ-008 SHALL implement FSM states IDLE, LEFT, RIGHT; IDLE after reset.
REQ-009 IDLE: data_out=4'b0000; first step -> LEFT, data_out=4'b0001, div_cnt=0, STEP_DIV ignored for this step.
REQ-010 SHALL keep a 4-bit div_cnt; on a step in LEFT/RIGHT, if div_cnt==STEP_DIV-1 then shift and clear div_cnt, else increment div_cnt with data_out held.
REQ-011 LEFT shift: data_out <= data_out<<1; reaching 4'b1000 -> RIGHT (bounce build) or stays LEFT (rotate build, REQ-017/018).
REQ-012 RIGHT shift: data_out <= data_out>>1; reaching 4'b0001 -> LEFT.
REQ-013 Latency: data_out changes on the same clk edge that captures the new addr into addr_q, i.e. one cycle after addr changes at the input.
REQ-014 data_out SHALL always be one-hot outside IDLE; no cycle with zero or multiple bits set.
REQ-015 addr wrap-around (12'hFFF -> 12'h000) SHALL be an ordinary step event.

Reset
REQ-016 en=1 SHALL, on the next edge and regardless of state or div_cnt: state=IDLE, data_out=4'b0000, div_cnt=0, addr_q=addr; no step is generated on the first cycle after en falls if addr is unchanged.
REQ-016a en asserted mid-shift SHALL abort the pattern; no residual step counted after release.

Configuration
REQ-017 Macro LED_SHIFT_BOUNCE_EN defined: LEFT/RIGHT ping-pong per REQ-011/012 (0001,0010,0100,1000,0100,0010,0001,...).
REQ-018 Macro LED_SHIFT_BOUNCE_EN undefined: RIGHT state not generated; LEFT rotates, 4'b1000 -> 4'b0001 (0001,0010,0100,1000,0001,...).

Verification
REQ-019 en=1 5 cycles with addr toggling, then en=0, addr constant 12'h123 -> data_out=0000, state IDLE, no step.
REQ-020 STEP_DIV=1, bounce build, addr incremented every 4 cycles from 0 for 8 steps -> data_out 0001,0010,0100,1000,0100,0010,0001,0010, each 1 cycle after addr change.
REQ-021 STEP_DIV=3, addr incremented every cycle for 7 steps -> 0001 after step 1, 0010 after step 4, 0100 after step 7, held between.
REQ-022 Rotate build, STEP_DIV=1, 5 steps -> 0001,0010,0100,1000,0001.
REQ-023 addr 12'hFFE -> 12'hFFF -> 12'h000 with data_out=0010 in LEFT, STEP_DIV=1 -> 0100 then 1000; wrap counted.
REQ-024 en pulsed 1 cycle while data_out=0100 and div_cnt=1 -> next cycle 0000/IDLE; next addr change -> 0001.
